// File: rtl/cpu_loader_pkg.sv
// Shared definitions for the cpu program loader.
// Holds the command and acknowledge byte codes, the loader FSM state
// encoding, the number of extra cycles cpu_reset is held after an X
// command, and a helper that joins two received bytes into a 16-bit word.
package cpu_loader_pkg;

    localparam logic [7:0] CmdLoad = 8'h4C;  // 'L'
    localparam logic [7:0] CmdExec = 8'h58;  // 'X'
    localparam logic [7:0] CmdHalt = 8'h48;  // 'H'
    localparam logic [7:0] AckErr  = 8'h21;  // '!' load refused, cpu running

    localparam int unsigned XRstHold = 2;

    typedef enum logic [3:0] {
        StIdle,
        StLAh,
        StLAl,
        StLNh,
        StLNl,
        StLData,
        StXAh,
        StXAl,
        StXRst,
        StHWait,
        StAck
    } state_t;

    function automatic logic [15:0] join_bytes(input logic [7:0] hi, input logic [7:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/cpu_loader_timer.sv
// loader_timer: reloadable idle down-counter.
// Ports:
//   clk     - clock
//   resetn  - asynchronous active-low reset
//   load    - reload the counter with `timeout`
//   expired - counter has run down to zero
module loader_timer #(
    parameter int unsigned timeout = 1200000
) (
    input  logic clk,
    input  logic resetn,
    input  logic load,
    output logic expired
);

    localparam int unsigned CntW = $clog2(timeout + 1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= CntW'(timeout);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/cpu_loader.sv
// cpu_loader: byte-serial program loader and run control for the cpu.
// Parses 'L' (load), 'X' (execute) and 'H' (halt) commands from the UART
// receiver, writes program bytes into the cpu's memory, drives the cpu
// reset/halt/start_address inputs and returns one ack byte per command.
// Ports:
//   clk, resetn                 - clock, asynchronous active-low reset
//   rx_data, rx_valid           - received byte and its one-cycle strobe
//   tx_data, tx_valid, tx_busy  - ack byte, its strobe, transmitter busy
//   mem_waddr, mem_data_in,
//   mem_write                   - program memory write port
//   cpu_reset, cpu_halt         - cpu control outputs
//   cpu_halted                  - cpu halted status
//   start_address               - cpu start address
module cpu_loader
    import cpu_loader_pkg::*;
#(
    parameter int unsigned addr_width = 9,
    parameter int unsigned timeout    = 1200000
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_busy,
    output logic [addr_width-1:0] mem_waddr,
    output logic [7:0]            mem_data_in,
    output logic                  mem_write,
    output logic                  cpu_reset,
    output logic                  cpu_halt,
    input  logic                  cpu_halted,
    output logic [addr_width-1:0] start_address
);

    state_t                state_q, state_d;
    logic [7:0]            hi_q, hi_d;      // addr_hi or len_hi, whichever came last
    logic [addr_width-1:0] addr_q, addr_d;
    logic [15:0]           len_q, len_d;
    logic [7:0]            sum_q, sum_d;
    logic [7:0]            ack_q, ack_d;
    logic [1:0]            hold_q, hold_d;

    logic                  cpu_reset_q, cpu_reset_d;
    logic                  cpu_halt_q, cpu_halt_d;
    logic [addr_width-1:0] start_q, start_d;
    logic                  mem_write_q, mem_write_d;
    logic [addr_width-1:0] mem_waddr_q, mem_waddr_d;
    logic [7:0]            mem_data_q, mem_data_d;
    logic                  tx_valid_q, tx_valid_d;
    logic [7:0]            tx_data_q, tx_data_d;

    logic                  timer_expired;
    logic                  timed;
    logic [15:0]           rx_word;

    loader_timer #(
        .timeout(timeout)
    ) u_timer (
        .clk    (clk),
        .resetn (resetn),
        .load   (rx_valid),
        .expired(timer_expired)
    );

    assign rx_word = join_bytes(hi_q, rx_data);

    always_comb begin
        state_d     = state_q;
        hi_d        = hi_q;
        addr_d      = addr_q;
        len_d       = len_q;
        sum_d       = sum_q;
        ack_d       = ack_q;
        hold_d      = hold_q;
        cpu_reset_d = cpu_reset_q;
        cpu_halt_d  = cpu_halt_q;
        start_d     = start_q;
        mem_write_d = 1'b0;
        mem_waddr_d = mem_waddr_q;
        mem_data_d  = mem_data_q;
        tx_valid_d  = 1'b0;
        tx_data_d   = tx_data_q;

        // Only states waiting on a parameter or data byte can time out;
        // X_RST is a fixed short hold and never waits for input.
        timed = state_q inside {StLAh, StLAl, StLNh, StLNl, StLData, StXAh, StXAl};

        unique case (state_q)
            StIdle: begin
                if (rx_valid) begin
                    case (rx_data)
                        CmdLoad: state_d = StLAh;
                        CmdExec: state_d = StXAh;
                        CmdHalt: begin
                            if (cpu_reset_q) begin
                                ack_d   = CmdHalt;
                                state_d = StAck;
                            end else begin
                                cpu_halt_d = 1'b1;
                                state_d    = StHWait;
                            end
                        end
                        default: state_d = StIdle;
                    endcase
                end
            end
            StLAh: begin
                if (rx_valid) begin
                    hi_d    = rx_data;
                    state_d = StLAl;
                end
            end
            StLAl: begin
                if (rx_valid) begin
                    addr_d  = addr_width'(rx_word);
                    state_d = StLNh;
                end
            end
            StLNh: begin
                if (rx_valid) begin
                    hi_d    = rx_data;
                    state_d = StLNl;
                end
            end
            StLNl: begin
                if (rx_valid) begin
                    len_d = rx_word;
                    sum_d = 8'h00;
                    if (rx_word == 16'h0000) begin
                        ack_d   = cpu_reset_q ? 8'h00 : AckErr;
                        state_d = StAck;
                    end else begin
                        state_d = StLData;
                    end
                end
            end
            StLData: begin
                if (rx_valid) begin
                    // A running cpu owns the memory: consume the bytes, write nothing.
                    if (cpu_reset_q) begin
                        mem_write_d = 1'b1;
                        mem_waddr_d = addr_q;
                        mem_data_d  = rx_data;
                    end
                    addr_d = addr_q + addr_width'(1);
                    sum_d  = sum_q + rx_data;
                    len_d  = len_q - 16'd1;
                    if (len_q == 16'd1) begin
                        ack_d   = cpu_reset_q ? (sum_q + rx_data) : AckErr;
                        state_d = StAck;
                    end
                end
            end
            StXAh: begin
                if (rx_valid) begin
                    hi_d    = rx_data;
                    state_d = StXAl;
                end
            end
            StXAl: begin
                if (rx_valid) begin
                    start_d     = addr_width'(rx_word);
                    cpu_reset_d = 1'b1;
                    hold_d      = 2'(XRstHold - 1);
                    state_d     = StXRst;
                end
            end
            StXRst: begin
                if (hold_q == 2'd0) begin
                    cpu_reset_d = 1'b0;
                    ack_d       = CmdExec;
                    state_d     = StAck;
                end else begin
                    hold_d = hold_q - 2'd1;
                end
            end
            StHWait: begin
                if (cpu_halted) begin
                    cpu_reset_d = 1'b1;
                    cpu_halt_d  = 1'b0;
                    ack_d       = CmdHalt;
                    state_d     = StAck;
                end
            end
            StAck: begin
                // Stay one cycle past the strobe so the pulse is never repeated.
                if (tx_valid_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (timed && !rx_valid && timer_expired) begin
            state_d = StIdle;
        end

        // Raise the strobe on ACK entry or while waiting in ACK, so the
        // registered tx_valid lands in the first ACK cycle when not busy.
        if (state_d == StAck && !tx_valid_q && !tx_busy) begin
            tx_valid_d = 1'b1;
            tx_data_d  = ack_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            hi_q        <= 8'h00;
            addr_q      <= '0;
            len_q       <= 16'h0000;
            sum_q       <= 8'h00;
            ack_q       <= 8'h00;
            hold_q      <= 2'd0;
            cpu_reset_q <= 1'b1;
            cpu_halt_q  <= 1'b0;
            start_q     <= '0;
            mem_write_q <= 1'b0;
            mem_waddr_q <= '0;
            mem_data_q  <= 8'h00;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            hi_q        <= hi_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            sum_q       <= sum_d;
            ack_q       <= ack_d;
            hold_q      <= hold_d;
            cpu_reset_q <= cpu_reset_d;
            cpu_halt_q  <= cpu_halt_d;
            start_q     <= start_d;
            mem_write_q <= mem_write_d;
            mem_waddr_q <= mem_waddr_d;
            mem_data_q  <= mem_data_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
        end
    end

    assign cpu_reset     = cpu_reset_q;
    assign cpu_halt      = cpu_halt_q;
    assign start_address = start_q;
    assign mem_write     = mem_write_q;
    assign mem_waddr     = mem_waddr_q;
    assign mem_data_in   = mem_data_q;
    assign tx_valid      = tx_valid_q;
    assign tx_data       = tx_data_q;

endmodule

// File: tb/tb_cpu_loader.sv
module tb_cpu_loader;

    localparam int AW = 9;
    localparam int TO = 100;

    logic          clk = 1'b0;
    logic          resetn = 1'b1;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_busy = 1'b0;
    logic [AW-1:0] mem_waddr;
    logic [7:0]    mem_data_in;
    logic          mem_write;
    logic          cpu_reset;
    logic          cpu_halt;
    logic          cpu_halted = 1'b0;
    logic [AW-1:0] start_address;

    cpu_loader #(
        .addr_width(AW),
        .timeout   (TO)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_busy      (tx_busy),
        .mem_waddr    (mem_waddr),
        .mem_data_in  (mem_data_in),
        .mem_write    (mem_write),
        .cpu_reset    (cpu_reset),
        .cpu_halt     (cpu_halt),
        .cpu_halted   (cpu_halted),
        .start_address(start_address)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [7:0]    d;
        int            c;
    } wr_t;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    wr_t           exp_wr[$];
    logic [7:0]    exp_ack[$];
    logic [7:0]    seen_mem [0:511];
    logic [7:0]    last_ack = 8'h00;
    int            ack_cyc = -1;
    int            ack_count = 0;
    bit            model_stopped = 1'b1;
    logic [AW-1:0] model_start = '0;
    bit            busy_prev = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string msg);
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL %s", msg);
    endtask

    // Compare process: every write and ack strobe is matched against the model queues.
    initial forever begin
        wr_t w;
        @(negedge clk);
        if (resetn) begin
            if (mem_write) begin
                if (exp_wr.size() == 0) begin
                    fail($sformatf("unexpected_write addr 0x%0h data 0x%0h, none required",
                                   mem_waddr, mem_data_in));
                end else begin
                    w = exp_wr.pop_front();
                    chk("write_addr", 32'(mem_waddr), 32'(w.a));
                    chk("write_data", 32'(mem_data_in), 32'(w.d));
                    chk("write_cycle", cyc, w.c);
                    seen_mem[mem_waddr] = mem_data_in;
                end
            end else if (exp_wr.size() != 0 && exp_wr[0].c < cyc) begin
                w = exp_wr.pop_front();
                fail($sformatf("missing_write addr 0x%0h data 0x%0h", w.a, w.d));
            end
            if (tx_valid) begin
                chk("tx_while_busy", 32'(busy_prev), 32'd0);
                if (exp_ack.size() == 0) begin
                    fail($sformatf("unexpected_ack got 0x%0h, none required", tx_data));
                end else begin
                    chk("ack_data", 32'(tx_data), 32'(exp_ack.pop_front()));
                end
                last_ack  = tx_data;
                ack_cyc   = cyc;
                ack_count = ack_count + 1;
            end
            chk("start_address", 32'(start_address), 32'(model_start));
        end
        busy_prev = tx_busy;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_ack(input int bound);
        int i;
        for (i = 0; i < bound && exp_ack.size() != 0; i++) idle(1);
        if (exp_ack.size() != 0) begin
            fail($sformatf("ack_timeout: %0d acks still pending after %0d cycles",
                           exp_ack.size(), bound));
            exp_ack.delete();
        end
    endtask

    task automatic model_reset();
        exp_wr.delete();
        exp_ack.delete();
        model_stopped = 1'b1;
        model_start   = '0;
    endtask

    // Byte i of `bytes` is bytes[8*i +: 8].
    task automatic cmd_load(input logic [15:0] addr, input int n, input logic [63:0] bytes,
                            input bit tchk);
        logic [7:0]    sum;
        logic [7:0]    b;
        logic [AW-1:0] a;
        logic [15:0]   len;
        wr_t           w;
        int            t;
        len = n[15:0];
        send_byte(8'h4C);
        send_byte(addr[15:8]);
        send_byte(addr[7:0]);
        send_byte(len[15:8]);
        send_byte(len[7:0]);
        sum = 8'h00;
        a   = addr[AW-1:0];
        for (int i = 0; i < n; i++) begin
            b = bytes[8*i +: 8];
            send_byte(b);
            if (model_stopped) begin
                w.a = a;
                w.d = b;
                w.c = cyc;
                exp_wr.push_back(w);
            end
            a   = a + 1'b1;
            sum = sum + b;
        end
        t = cyc;
        exp_ack.push_back(model_stopped ? sum : 8'h21);
        if (tchk) begin
            wait_ack(50);
            chk("load_ack_cycle", ack_cyc, t);
        end
    endtask

    task automatic cmd_exec(input logic [15:0] addr);
        int t;
        send_byte(8'h58);
        send_byte(addr[15:8]);
        send_byte(addr[7:0]);
        t             = cyc;
        model_start   = addr[AW-1:0];
        model_stopped = 1'b0;
        exp_ack.push_back(8'h58);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("x_cpu_reset_n+%0d", k + 1), 32'(cpu_reset), (k < 2) ? 32'd1 : 32'd0);
            @(posedge clk);
            #1;
        end
        wait_ack(50);
        chk("x_ack_not_early", 32'(ack_cyc >= t + 2), 32'd1);
    endtask

    initial begin
        int t;
        int n_acks;
        for (int i = 0; i < 512; i++) seen_mem[i] = 8'hxx;

        #2 resetn = 1'b0;
        #1;
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_cpu_halt", 32'(cpu_halt), 32'd0);
        chk("rst_start_address", 32'(start_address), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_mem_waddr", 32'(mem_waddr), 32'd0);
        chk("rst_mem_data_in", 32'(mem_data_in), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Junk bytes in IDLE produce nothing.
        send_byte(8'h00);
        send_byte(8'h23);
        idle(3);

        // H while stopped: immediate ack.
        send_byte(8'h48);
        t = cyc;
        exp_ack.push_back(8'h48);
        wait_ack(20);
        chk("h_stopped_ack_cycle", ack_cyc, t);
        chk("h_stopped_ack", 32'(last_ack), 32'h48);

        // Load with address wrap.
        cmd_load(16'h01FE, 3, 64'h0000_0000_0033_2211, 1'b1);
        chk("mem_1fe", 32'(seen_mem[9'h1FE]), 32'h11);
        chk("mem_1ff", 32'(seen_mem[9'h1FF]), 32'h22);
        chk("mem_000", 32'(seen_mem[9'h000]), 32'h33);
        chk("load_sum_ack", 32'(last_ack), 32'h66);

        // Start the cpu.
        cmd_exec(16'h0010);
        chk("x_start_literal", 32'(start_address), 32'h010);
        chk("x_ack", 32'(last_ack), 32'h58);
        chk("x_running", 32'(cpu_reset), 32'd0);

        // Load refused while running.
        cmd_load(16'h0000, 1, 64'hAA, 1'b1);
        chk("load_running_ack", 32'(last_ack), 32'h21);

        // H while running, cpu reports halted 20 cycles later.
        send_byte(8'h48);
        @(negedge clk);
        chk("h_halt_rises", 32'(cpu_halt), 32'd1);
        chk("h_reset_still_low", 32'(cpu_reset), 32'd0);
        @(posedge clk);
        #1;
        idle(18);
        cpu_halted = 1'b1;
        t = cyc;
        exp_ack.push_back(8'h48);
        model_stopped = 1'b1;
        @(negedge clk);
        chk("h_reset_before_m1", 32'(cpu_reset), 32'd0);
        chk("h_halt_before_m1", 32'(cpu_halt), 32'd1);
        @(posedge clk);
        #1;
        cpu_halted = 1'b0;
        @(negedge clk);
        chk("h_reset_at_m1", 32'(cpu_reset), 32'd1);
        chk("h_halt_at_m1", 32'(cpu_halt), 32'd0);
        @(posedge clk);
        #1;
        wait_ack(20);
        chk("h_running_ack_cycle", ack_cyc, t + 1);
        chk("h_running_ack", 32'(last_ack), 32'h48);

        // Abandoned command times out silently.
        n_acks = ack_count;
        send_byte(8'h4C);
        send_byte(8'h00);
        idle(TO + 10);
        chk("timeout_no_ack", ack_count, n_acks);
        cmd_load(16'h0000, 0, 64'h0, 1'b1);
        chk("len0_ack", 32'(last_ack), 32'h00);

        // Ack deferred while transmitter busy.
        tx_busy = 1'b1;
        n_acks  = ack_count;
        cmd_load(16'h0040, 0, 64'h0, 1'b0);
        idle(50);
        chk("busy_ack_held", ack_count, n_acks);
        tx_busy = 1'b0;
        t = cyc;
        wait_ack(20);
        chk("busy_ack_cycle", ack_cyc, t + 1);
        chk("busy_ack", 32'(last_ack), 32'h00);

        // Asynchronous reset in the middle of L_DATA with the cpu running.
        cmd_exec(16'h0123);
        send_byte(8'h4C);
        send_byte(8'h00);
        send_byte(8'h20);
        send_byte(8'h00);
        send_byte(8'h04);
        send_byte(8'h01);
        send_byte(8'h02);
        #2 resetn = 1'b0;
        #1;
        chk("mid_rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("mid_rst_start_address", 32'(start_address), 32'd0);
        chk("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("mid_rst_mem_write", 32'(mem_write), 32'd0);
        chk("mid_rst_cpu_halt", 32'(cpu_halt), 32'd0);
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        send_byte(8'h48);
        t = cyc;
        exp_ack.push_back(8'h48);
        wait_ack(20);
        chk("post_rst_h_ack_cycle", ack_cyc, t);
        cmd_load(16'h0030, 1, 64'h5A, 1'b1);
        chk("post_rst_mem_030", 32'(seen_mem[9'h030]), 32'h5A);
        chk("post_rst_load_ack", 32'(last_ack), 32'h5A);

        idle(5);
        chk("writes_drained", exp_wr.size(), 0);
        chk("acks_drained", exp_ack.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
